// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state/parity types and defaults
package uart_pkg;

    localparam int OVRSMPL_DEFAULT = 16;

    typedef enum logic [5:0] {
        IDLE      = 6'b000001,
        START     = 6'b000010,
        DATA      = 6'b000100,
        PARITY    = 6'b001000,
        STOP      = 6'b010000,
        WAIT_HIGH = 6'b100000
    } rx_state_e;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_e;

    // Encoding 3 is reserved and behaves as no parity.
    function automatic parity_e to_parity(input logic [1:0] code);
        case (code)
            2'd1:    return PAR_EVEN;
            2'd2:    return PAR_ODD;
            default: return PAR_NONE;
        endcase
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - dvsr prescaler producing one oversample tick per dvsr clocks
module uart_baud_tick #(
    parameter int W_DVSR = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              restart,
    input  logic [W_DVSR-1:0] dvsr,
    output logic              tick
);

    logic [W_DVSR-1:0] cnt;
    logic [W_DVSR-1:0] last;

    // A divisor of 0 behaves like 1: tick every clock.
    assign last = (dvsr == '0) ? '0 : dvsr - 1'b1;
    assign tick = !restart && (cnt >= last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (restart || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_cfg.sv
// rtl/uart_rx_cfg.sv - configurable 16x oversampled UART receiver; UART_RX_MAJORITY_VOTE_EN enables 3-sample voting
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int W_DATA_MAX = 8,
    parameter int W_DVSR     = 16,
    parameter int OVRSMPL    = OVRSMPL_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [W_DVSR-1:0]     dvsr,
    input  logic [3:0]            cfg_data_bits,
    input  logic [1:0]            cfg_parity,
    input  logic                  cfg_stop2,
    input  logic                  rx_din,
    output logic [W_DATA_MAX-1:0] rx_dout,
    output logic                  rx_valid,
    output logic                  parity_error,
    output logic                  framing_error,
    output logic                  break_detect
);

    localparam int W_TICK = $clog2(OVRSMPL);
    localparam int HALF   = OVRSMPL / 2;
`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam int MV_SHIFT = 1;
`else
    localparam int MV_SHIFT = 0;
`endif
    // With voting the decision lands one tick after the nominal centre.
    localparam logic [W_TICK-1:0] START_PT  = W_TICK'(HALF - 1 + MV_SHIFT);
    localparam logic [W_TICK-1:0] BIT_PT    = W_TICK'(OVRSMPL - 1);
    localparam logic [3:0]        NBITS_MIN = 4'd5;
    localparam logic [3:0]        NBITS_MAX = 4'(W_DATA_MAX);

    rx_state_e             state, state_nxt;
    logic [W_TICK-1:0]     tick_no, tick_no_nxt;
    logic [3:0]            bit_no, bit_no_nxt;
    logic [W_DATA_MAX-1:0] shreg, shreg_nxt;
    logic                  stop2nd, stop2nd_nxt;
    logic                  par_err_r, par_err_nxt;
    logic                  par_bit_r, par_bit_nxt;

    logic [3:0]            cfg_nbits;
    parity_e               cfg_par;
    logic                  cfg_two_stop;
    logic [3:0]            nbits_in;

    logic                  sync1, rx_s;
    logic                  tick;
    logic                  start_edge;
    logic [W_TICK-1:0]     sample_pt;
    logic                  at_sample;
    logic                  bit_val;
    logic                  frame_end;
    logic                  frame_ferr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= rx_din;
            rx_s  <= sync1;
        end
    end

    assign start_edge = (state == IDLE) && !rx_s;

    uart_baud_tick #(
        .W_DVSR (W_DVSR)
    ) u_baud_tick (
        .clk     (clk),
        .rst     (rst),
        .restart (start_edge),
        .dvsr    (dvsr),
        .tick    (tick)
    );

    always_comb begin
        nbits_in = cfg_data_bits;
        if (cfg_data_bits < NBITS_MIN) begin
            nbits_in = NBITS_MIN;
        end else if (cfg_data_bits > NBITS_MAX) begin
            nbits_in = NBITS_MAX;
        end
    end

    // Frame format is frozen at the start edge so mid-frame edits wait a frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_nbits    <= NBITS_MAX;
            cfg_par      <= PAR_NONE;
            cfg_two_stop <= 1'b0;
        end else if (start_edge) begin
            cfg_nbits    <= nbits_in;
            cfg_par      <= to_parity(cfg_parity);
            cfg_two_stop <= cfg_stop2;
        end
    end

    assign sample_pt = (state == START) ? START_PT : BIT_PT;
    assign at_sample = tick && (tick_no == sample_pt);

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic vote_a, vote_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vote_a <= 1'b1;
            vote_b <= 1'b1;
        end else if (tick) begin
            if (tick_no == sample_pt - W_TICK'(2)) vote_a <= rx_s;
            if (tick_no == sample_pt - W_TICK'(1)) vote_b <= rx_s;
        end
    end

    assign bit_val = (vote_a & vote_b) | (vote_a & rx_s) | (vote_b & rx_s);
`else
    assign bit_val = rx_s;
`endif

    always_comb begin
        state_nxt   = state;
        tick_no_nxt = tick_no;
        bit_no_nxt  = bit_no;
        shreg_nxt   = shreg;
        stop2nd_nxt = stop2nd;
        par_err_nxt = par_err_r;
        par_bit_nxt = par_bit_r;
        frame_end   = 1'b0;
        frame_ferr  = 1'b0;

        if (tick && (state != IDLE) && (state != WAIT_HIGH)) begin
            tick_no_nxt = tick_no + 1'b1;
        end

        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_nxt   = START;
                    tick_no_nxt = '0;
                end
            end
            START: begin
                if (at_sample) begin
                    if (bit_val) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt   = DATA;
                        tick_no_nxt = '0;
                        bit_no_nxt  = '0;
                        shreg_nxt   = '0;
                        stop2nd_nxt = 1'b0;
                        par_err_nxt = 1'b0;
                        par_bit_nxt = 1'b0;
                    end
                end
            end
            DATA: begin
                if (at_sample) begin
                    shreg_nxt   = {bit_val, shreg[W_DATA_MAX-1:1]};
                    tick_no_nxt = '0;
                    bit_no_nxt  = bit_no + 4'd1;
                    if (bit_no + 4'd1 == cfg_nbits) begin
                        state_nxt = (cfg_par == PAR_NONE) ? STOP : PARITY;
                    end
                end
            end
            PARITY: begin
                if (at_sample) begin
                    par_bit_nxt = bit_val;
                    par_err_nxt = ((^shreg) ^ bit_val) != (cfg_par == PAR_ODD);
                    tick_no_nxt = '0;
                    state_nxt   = STOP;
                end
            end
            STOP: begin
                if (at_sample) begin
                    tick_no_nxt = '0;
                    if (!bit_val) begin
                        frame_end  = 1'b1;
                        frame_ferr = 1'b1;
                        state_nxt  = WAIT_HIGH;
                    end else if (cfg_two_stop && !stop2nd) begin
                        stop2nd_nxt = 1'b1;
                    end else begin
                        frame_end = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            WAIT_HIGH: begin
                if (rx_s) state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            tick_no   <= '0;
            bit_no    <= '0;
            shreg     <= '0;
            stop2nd   <= 1'b0;
            par_err_r <= 1'b0;
            par_bit_r <= 1'b0;
        end else begin
            state     <= state_nxt;
            tick_no   <= tick_no_nxt;
            bit_no    <= bit_no_nxt;
            shreg     <= shreg_nxt;
            stop2nd   <= stop2nd_nxt;
            par_err_r <= par_err_nxt;
            par_bit_r <= par_bit_nxt;
        end
    end

    // Data arrives MSB-aligned in shreg; shifting down right-justifies it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_dout       <= '0;
            rx_valid      <= 1'b0;
            parity_error  <= 1'b0;
            framing_error <= 1'b0;
            break_detect  <= 1'b0;
        end else begin
            rx_valid <= frame_end;
            if (frame_end) begin
                rx_dout       <= shreg >> (NBITS_MAX - cfg_nbits);
                parity_error  <= par_err_r;
                framing_error <= frame_ferr;
                break_detect  <= frame_ferr && (shreg == '0) &&
                                 ((cfg_par == PAR_NONE) || !par_bit_r);
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb/tb_uart_rx_cfg.sv - directed self-checking bench for uart_rx_cfg
module tb_uart_rx_cfg;
    import uart_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] dvsr;
    logic [3:0]  cfg_data_bits;
    logic [1:0]  cfg_parity;
    logic        cfg_stop2;
    logic        rx_din;
    logic [7:0]  rx_dout;
    logic        rx_valid;
    logic        parity_error;
    logic        framing_error;
    logic        break_detect;

    int tests = 0;
    int failed = 0;
    int cyc = 0;
    int fall_cyc = 0;
    int cap_cyc = 0;
    int valid_cnt = 0;
    int vc0 = 0;
    int lat = 0;
`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam int LAT_EXP = 156;
`else
    localparam int LAT_EXP = 155;
`endif

    uart_rx_cfg #(
        .W_DATA_MAX (8),
        .W_DVSR     (16),
        .OVRSMPL    (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .dvsr          (dvsr),
        .cfg_data_bits (cfg_data_bits),
        .cfg_parity    (cfg_parity),
        .cfg_stop2     (cfg_stop2),
        .rx_din        (rx_din),
        .rx_dout       (rx_dout),
        .rx_valid      (rx_valid),
        .parity_error  (parity_error),
        .framing_error (framing_error),
        .break_detect  (break_detect)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_valid) begin
            valid_cnt <= valid_cnt + 1;
            cap_cyc   <= cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic b, input int n);
        rx_din = b;
        repeat (n) @(negedge clk);
    endtask

    // par: 0 none, 1 even, 2 odd; glitch_bit inverts one clock mid-bit (dvsr=1 only)
    task automatic send_frame(input logic [7:0] d, input int nb, input int par,
                              input logic flip_par, input int nstop,
                              input logic stop_lvl, input int dv, input int glitch_bit);
        int   bt;
        logic p;
        bt = 16 * dv;
        fall_cyc = cyc;
        drive(1'b0, bt);
        for (int i = 0; i < nb; i++) begin
            if (i == glitch_bit) begin
                drive(d[i], 8);
                drive(~d[i], 1);
                drive(d[i], bt - 9);
            end else begin
                drive(d[i], bt);
            end
        end
        if (par != 0) begin
            p = ^d;
            if (par == 2) p = ~p;
            if (flip_par) p = ~p;
            drive(p, bt);
        end
        drive(stop_lvl, bt);
        if (nstop == 2) drive(1'b1, bt);
    endtask

    initial begin
        rst = 1'b1;
        rx_din = 1'b1;
        dvsr = 16'd1;
        cfg_data_bits = 4'd8;
        cfg_parity = 2'd0;
        cfg_stop2 = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_dout", rx_dout, 8'h00);
        check("rst_valid", rx_valid, 1'b0);
        check("rst_flags", {parity_error, framing_error, break_detect}, 3'b000);
        check("rst_state", dut.state == IDLE, 1'b1);
        rst = 1'b0;
        drive(1'b1, 20);

        // 8N1 0xA5, dvsr=1
        vc0 = valid_cnt;
        send_frame(8'hA5, 8, 0, 1'b0, 1, 1'b1, 1, -1);
        drive(1'b1, 20);
        lat = cap_cyc - fall_cyc;
        check("a5_count", valid_cnt - vc0, 1);
        check("a5_latency_in_window", (lat >= LAT_EXP - 1) && (lat <= LAT_EXP + 1), 1'b1);
        check("a5_dout", rx_dout, 8'hA5);
        check("a5_flags", {parity_error, framing_error, break_detect}, 3'b000);

        // 4-clock glitch: false start
        vc0 = valid_cnt;
        drive(1'b0, 4);
        check("glitch_in_start", dut.state == START, 1'b1);
        drive(1'b1, 30);
        check("glitch_back_idle", dut.state == IDLE, 1'b1);
        check("glitch_count", valid_cnt - vc0, 0);
        check("glitch_dout_held", rx_dout, 8'hA5);

        // 7E2 0x35, dvsr=3, good parity then bad parity
        dvsr = 16'd3;
        cfg_data_bits = 4'd7;
        cfg_parity = 2'd1;
        cfg_stop2 = 1'b1;
        vc0 = valid_cnt;
        send_frame(8'h35, 7, 1, 1'b0, 2, 1'b1, 3, -1);
        drive(1'b1, 30);
        check("7e2_count", valid_cnt - vc0, 1);
        check("7e2_dout", rx_dout, 8'h35);
        check("7e2_flags", {parity_error, framing_error, break_detect}, 3'b000);
        vc0 = valid_cnt;
        send_frame(8'h35, 7, 1, 1'b1, 2, 1'b1, 3, -1);
        drive(1'b1, 30);
        check("7e2_bad_count", valid_cnt - vc0, 1);
        check("7e2_bad_dout", rx_dout, 8'h35);
        check("7e2_bad_flags", {parity_error, framing_error, break_detect}, 3'b100);

        // 5O1 0x1F with stop low, then 0x0A
        dvsr = 16'd1;
        cfg_data_bits = 4'd5;
        cfg_parity = 2'd2;
        cfg_stop2 = 1'b0;
        vc0 = valid_cnt;
        send_frame(8'h1F, 5, 2, 1'b0, 1, 1'b0, 1, -1);
        drive(1'b0, 100);
        check("5o1_fe_count", valid_cnt - vc0, 1);
        check("5o1_fe_dout", rx_dout, 8'h1F);
        check("5o1_fe_flags", {parity_error, framing_error, break_detect}, 3'b010);
        check("5o1_wait_high", dut.state == WAIT_HIGH, 1'b1);
        drive(1'b1, 30);
        check("5o1_idle_after_rise", dut.state == IDLE, 1'b1);
        vc0 = valid_cnt;
        send_frame(8'h0A, 5, 2, 1'b0, 1, 1'b1, 1, -1);
        drive(1'b1, 30);
        check("5o1_next_count", valid_cnt - vc0, 1);
        check("5o1_next_dout", rx_dout, 8'h0A);
        check("5o1_next_flags", {parity_error, framing_error, break_detect}, 3'b000);

        // Out-of-range config clamps to 8 bits, parity code 3 means none
        cfg_data_bits = 4'd12;
        cfg_parity = 2'd3;
        vc0 = valid_cnt;
        send_frame(8'hC3, 8, 0, 1'b0, 1, 1'b1, 1, -1);
        drive(1'b1, 20);
        check("clamp_count", valid_cnt - vc0, 1);
        check("clamp_dout", rx_dout, 8'hC3);
        check("clamp_flags", {parity_error, framing_error, break_detect}, 3'b000);

        // Break: line low for two 8N1 frame times
        cfg_data_bits = 4'd8;
        cfg_parity = 2'd0;
        vc0 = valid_cnt;
        drive(1'b0, 320);
        check("brk_count", valid_cnt - vc0, 1);
        check("brk_dout", rx_dout, 8'h00);
        check("brk_flags", {parity_error, framing_error, break_detect}, 3'b011);
        drive(1'b1, 40);
        check("brk_no_more_valid", valid_cnt - vc0, 1);
        check("brk_idle", dut.state == IDLE, 1'b1);

        // Reset during DATA, then a clean 0x5A
        drive(1'b0, 16);
        drive(1'b0, 16);
        drive(1'b1, 16);
        drive(1'b0, 16);
        check("mid_in_data", dut.state == DATA, 1'b1);
        rst = 1'b1;
        #1;
        check("mid_rst_dout", rx_dout, 8'h00);
        check("mid_rst_outs", {rx_valid, parity_error, framing_error, break_detect}, 4'b0000);
        check("mid_rst_state", dut.state == IDLE, 1'b1);
        rx_din = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 20);
        vc0 = valid_cnt;
        send_frame(8'h5A, 8, 0, 1'b0, 1, 1'b1, 1, -1);
        drive(1'b1, 20);
        check("post_rst_count", valid_cnt - vc0, 1);
        check("post_rst_dout", rx_dout, 8'h5A);
        check("post_rst_flags", {parity_error, framing_error, break_detect}, 3'b000);

`ifdef UART_RX_MAJORITY_VOTE_EN
        vc0 = valid_cnt;
        send_frame(8'hA5, 8, 0, 1'b0, 1, 1'b1, 1, 2);
        drive(1'b1, 20);
        check("mv_glitch_count", valid_cnt - vc0, 1);
        check("mv_glitch_dout", rx_dout, 8'hA5);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
